decode_stage_pl: RTL and testbench
==================================

Name: decode_stage_pl

Overview:
Parametrised, registered successor to the combinational decode stage. It decodes the 16-bit WISC instruction, reads an internal 16-entry register file (with optional WB-to-ID bypass), and resolves branches in decode. It detects load-use, flag and BR-source hazards and stalls accordingly. Decoded fields are captured in an ID/EX output register with valid/ready handshaking, and branch/misprediction performance counters are kept.

Parameters:
DATA_WIDTH, 16, register/ALU operand width; must be >=16.
PC_WIDTH, 16, PC width; must be >=10.
BYPASS_EN, 1, 1 = a same-cycle WB write to the register being read is forwarded to the read data.
CNT_W, 16, width of the performance counters.

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
if_valid  in  1  IF/ID holds a valid instruction
if_inst  in  16  instruction word
if_pc_next  in  PC_WIDTH  address of the next sequential instruction
if_pred_taken  in  1  fetch-stage prediction
id_ready  out  1  decode accepts the instruction this cycle
flags  in  3  {ZF,VF,NF} from the flag register
wb_we  in  1  register-file write enable
wb_rd  in  4  write register id
wb_data  in  DATA_WIDTH  write data
mem_valid, mem_regwrite  in  1 each  MEM-stage instruction valid / writes a register
mem_rd  in  4  MEM-stage destination id
ex_ready  in  1  EX stage can accept
ex_valid  out  1  ID/EX register holds a valid instruction
ex_src1_id, ex_src2_id, ex_rd  out  4 each  register ids
ex_op1, ex_op2, ex_imm, ex_memdata  out  DATA_WIDTH each  ALU in1, ALU in2, immediate, store data
ex_aluop  out  4  ALU operation
ex_ctrl  out  9  {ALUSrc,Z_en,NV_en,MemEnable,MemWrite,RegWrite,MemToReg,HLT,PCS}
ex_pc_next  out  PC_WIDTH  pipelined if_pc_next (for PCS)
redirect  out  1  branch misprediction at fire (combinational)
redirect_pc  out  PC_WIDTH  correct fetch PC when redirect is high
branch_cnt, mispred_cnt  out  CNT_W each  counters

Behaviour:
- Control decode uses the existing ControlUnit opcode map: B=0xC, BR=0xD, LW=0x8, SW=0x9, LLB=0xA, LHB=0xB, PCS=0xE, HLT=0xF.
- Source select: src1 = rd[11:8] for LLB/LHB, otherwise rs[7:4]. src2 = rd for SW, otherwise rt[3:0].
- Immediate extension:
  - LW/SW: sign-extend inst[3:0].
  - LLB/LHB: zero-extend inst[7:0].
  - Others: zero-extend inst[3:0].
  - op2 = ALUSrc ? imm : rf[src2].
- Register file: 16 x DATA_WIDTH, asynchronous read, written on clk edge when wb_we. R0 reads as 0 and writes to R0 are ignored. With BYPASS_EN=1, a read of wb_rd (nonzero) while wb_we returns wb_data. With BYPASS_EN=0 it returns the old value.
- Branch condition on {Z,V,N}:
  - 000 Z=0
  - 001 Z=1
  - 010 Z=0 & N=0
  - 011 N=1
  - 100 Z | (~Z & ~N)
  - 101 N | Z
  - 110 V=1
  - 111 always
- Branch target: B uses if_pc_next + (sext(inst[8:0])<<1), modulo 2^PC_WIDTH. BR uses rf[rs][PC_WIDTH-1:0].
- Hazard stall (only when if_valid); R0 sources never hazard:
  - Load-use: ex_valid & MemToReg & ex_rd == a used source.
  - Flag hazard: conditional B/BR (cc!=111) while ex_valid & (Z_en|NV_en).
  - BR source: BR rs == ex_rd (ex_valid & RegWrite), or rs == mem_rd (mem_valid & mem_regwrite).
- Handshake:
  - id_ready = ~halted & ~stall & (ex_ready | ~ex_valid).
  - fire = if_valid & id_ready.
- ID/EX register:
  - Loads when ex_ready | ~ex_valid: it takes the decoded instruction with ex_valid=1 on fire, otherwise a bubble with ex_valid=0 and ex_ctrl=0.
  - Otherwise it holds all fields.
- Redirect: redirect = fire & branch & (taken != if_pred_taken). redirect_pc = taken ? target : if_pc_next. Both are 0 when not firing.
- Counters: branch_cnt increments on fire of B/BR, and mispred_cnt on redirect. Both saturate at all-ones.
- HLT: when HLT fires, halted is set and id_ready stays 0 until rst. The HLT instruction itself enters ID/EX.
- Simultaneous events: a WB write in the same cycle as a read follows BYPASS_EN. A stall with ex_ready=1 inserts a bubble.
- Reset: all outputs, counters, halted and register file are 0. Reset asserted mid-stall discards the pending instruction.

Test Plan:
1. wb writes R3=0x1234 while ADD R1,R3,R4 is decoded, BYPASS_EN=1 -> ex_op1=0x1234 next cycle. With BYPASS_EN=0 -> ex_op1=old value.
2. LW R2 in ID/EX, then ADD R5,R2,R6 -> id_ready=0 for 1 cycle with a bubble (ex_valid=0), then ADD is issued.
3. B cc=001, flags Z=1, pc_next=0x0010, imm=0x1FE, pred=0 -> redirect=1, redirect_pc=0x000C, branch_cnt=1, mispred_cnt=1.
4. SUB in ID/EX (Z_en=1), then B cc=000 -> stall 1 cycle. B cc=111 in the same situation -> no stall.
5. ex_ready=0 for 3 cycles with ID/EX valid -> all ex_* outputs are held and id_ready=0.
6. HLT fires -> halted, id_ready=0 with if_valid=1 for 10 cycles; rst -> all outputs and counters are 0.

Source files
------------

// File: rtl/decode_stage_pl.sv
`default_nettype none
// ============================================================================
// Module   : decode_stage_pl
// Brief    : Registered WISC decode stage with register file, in-decode branch
//            resolution, hazard stalls, ID/EX handshake and branch counters.
// Revision : 1.0  initial release
// ============================================================================
module decode_stage_pl #(
  parameter int DATA_WIDTH = 16,
  parameter int PC_WIDTH   = 16,
  parameter int BYPASS_EN  = 1,
  parameter int CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  if_valid,
  input  logic [15:0]           if_inst,
  input  logic [PC_WIDTH-1:0]   if_pc_next,
  input  logic                  if_pred_taken,
  output logic                  id_ready,
  input  logic [2:0]            flags,
  input  logic                  wb_we,
  input  logic [3:0]            wb_rd,
  input  logic [DATA_WIDTH-1:0] wb_data,
  input  logic                  mem_valid,
  input  logic                  mem_regwrite,
  input  logic [3:0]            mem_rd,
  input  logic                  ex_ready,
  output logic                  ex_valid,
  output logic [3:0]            ex_src1_id,
  output logic [3:0]            ex_src2_id,
  output logic [3:0]            ex_rd,
  output logic [DATA_WIDTH-1:0] ex_op1,
  output logic [DATA_WIDTH-1:0] ex_op2,
  output logic [DATA_WIDTH-1:0] ex_imm,
  output logic [DATA_WIDTH-1:0] ex_memdata,
  output logic [3:0]            ex_aluop,
  output logic [8:0]            ex_ctrl,
  output logic [PC_WIDTH-1:0]   ex_pc_next,
  output logic                  redirect,
  output logic [PC_WIDTH-1:0]   redirect_pc,
  output logic [CNT_W-1:0]      branch_cnt,
  output logic [CNT_W-1:0]      mispred_cnt
);

  localparam logic [3:0] c_OP_ADD    = 4'h0;
  localparam logic [3:0] c_OP_SUB    = 4'h1;
  localparam logic [3:0] c_OP_RED    = 4'h3;
  localparam logic [3:0] c_OP_SLL    = 4'h4;
  localparam logic [3:0] c_OP_SRA    = 4'h5;
  localparam logic [3:0] c_OP_ROR    = 4'h6;
  localparam logic [3:0] c_OP_PADDSB = 4'h7;
  localparam logic [3:0] c_OP_LW     = 4'h8;
  localparam logic [3:0] c_OP_SW     = 4'h9;
  localparam logic [3:0] c_OP_LLB    = 4'hA;
  localparam logic [3:0] c_OP_LHB    = 4'hB;
  localparam logic [3:0] c_OP_B      = 4'hC;
  localparam logic [3:0] c_OP_BR     = 4'hD;
  localparam logic [3:0] c_OP_PCS    = 4'hE;
  localparam logic [3:0] c_OP_HLT    = 4'hF;

  logic [DATA_WIDTH-1:0] r_rf [16];
  logic                  r_halted;
  logic                  r_ex_valid;
  logic [3:0]            r_ex_src1, r_ex_src2, r_ex_rd, r_ex_aluop;
  logic [DATA_WIDTH-1:0] r_ex_op1, r_ex_op2, r_ex_imm, r_ex_memdata;
  logic [8:0]            r_ex_ctrl;
  logic [PC_WIDTH-1:0]   r_ex_pc_next;
  logic [CNT_W-1:0]      r_branch_cnt, r_mispred_cnt;

  logic [3:0]            w_opc, w_rd_id, w_rs_id, w_rt_id, w_src1, w_src2, w_aluop;
  logic [2:0]            w_cc;
  logic                  w_is_lw, w_is_sw, w_is_ll, w_is_b, w_is_br, w_is_pcs, w_is_hlt;
  logic                  w_is_shift, w_is_alu, w_is_branch;
  logic                  w_alusrc, w_zen, w_nven, w_regwrite, w_use1, w_use2;
  logic [8:0]            w_ctrl;
  logic [DATA_WIDTH-1:0] w_rdata1, w_rdata2, w_imm, w_op2;
  logic                  w_cond, w_taken;
  logic [PC_WIDTH-1:0]   w_b_off, w_b_tgt, w_br_tgt, w_tgt;
  logic                  w_lu_haz, w_flag_haz, w_brs_haz, w_stall, w_load, w_fire;

  assign w_opc   = if_inst[15:12];
  assign w_rd_id = if_inst[11:8];
  assign w_rs_id = if_inst[7:4];
  assign w_rt_id = if_inst[3:0];
  assign w_cc    = if_inst[11:9];

  assign w_is_lw     = (w_opc == c_OP_LW);
  assign w_is_sw     = (w_opc == c_OP_SW);
  assign w_is_ll     = (w_opc == c_OP_LLB) || (w_opc == c_OP_LHB);
  assign w_is_b      = (w_opc == c_OP_B);
  assign w_is_br     = (w_opc == c_OP_BR);
  assign w_is_pcs    = (w_opc == c_OP_PCS);
  assign w_is_hlt    = (w_opc == c_OP_HLT);
  assign w_is_shift  = (w_opc == c_OP_SLL) || (w_opc == c_OP_SRA) || (w_opc == c_OP_ROR);
  assign w_is_alu    = ~w_opc[3];
  assign w_is_branch = w_is_b | w_is_br;

  // RED and PADDSB leave the flags alone; shifts and XOR update only Z
  assign w_alusrc   = w_is_shift | w_is_lw | w_is_sw | w_is_ll;
  assign w_zen      = w_is_alu & (w_opc != c_OP_RED) & (w_opc != c_OP_PADDSB);
  assign w_nven     = (w_opc == c_OP_ADD) || (w_opc == c_OP_SUB);
  assign w_regwrite = w_is_alu | w_is_lw | w_is_ll | w_is_pcs;
  assign w_ctrl     = {w_alusrc, w_zen, w_nven, w_is_lw | w_is_sw, w_is_sw,
                       w_regwrite, w_is_lw, w_is_hlt, w_is_pcs};
  assign w_aluop    = (w_is_lw | w_is_sw) ? c_OP_ADD : w_opc;

  assign w_src1 = w_is_ll ? w_rd_id : w_rs_id;
  assign w_src2 = w_is_sw ? w_rd_id : w_rt_id;
  assign w_use1 = ~(w_is_b | w_is_pcs | w_is_hlt);
  assign w_use2 = (w_is_alu & ~w_is_shift) | w_is_sw;

  always_comb begin
    w_rdata1 = (w_src1 == 4'd0) ? '0 : r_rf[w_src1];
    w_rdata2 = (w_src2 == 4'd0) ? '0 : r_rf[w_src2];
    if ((BYPASS_EN != 0) && wb_we && (wb_rd != 4'd0)) begin
      if (wb_rd == w_src1) w_rdata1 = wb_data;
      if (wb_rd == w_src2) w_rdata2 = wb_data;
    end
  end

  always_comb begin
    if (w_is_lw || w_is_sw)
      w_imm = {{(DATA_WIDTH-4){if_inst[3]}}, if_inst[3:0]};
    else if (w_is_ll)
      w_imm = {{(DATA_WIDTH-8){1'b0}}, if_inst[7:0]};
    else
      w_imm = {{(DATA_WIDTH-4){1'b0}}, if_inst[3:0]};
  end

  assign w_op2 = w_alusrc ? w_imm : w_rdata2;

  // flags arrive as {Z,V,N}
  always_comb begin
    case (w_cc)
      3'b000:  w_cond = ~flags[2];
      3'b001:  w_cond = flags[2];
      3'b010:  w_cond = ~flags[2] & ~flags[0];
      3'b011:  w_cond = flags[0];
      3'b100:  w_cond = flags[2] | (~flags[2] & ~flags[0]);
      3'b101:  w_cond = flags[0] | flags[2];
      3'b110:  w_cond = flags[1];
      default: w_cond = 1'b1;
    endcase
  end

  assign w_taken = w_is_branch & w_cond;
  assign w_b_off = {{(PC_WIDTH-9){if_inst[8]}}, if_inst[8:0]};
  assign w_b_tgt = if_pc_next + (w_b_off << 1);

  if (PC_WIDTH <= DATA_WIDTH) begin : g_br_tgt_slice
    assign w_br_tgt = w_rdata1[PC_WIDTH-1:0];
  end else begin : g_br_tgt_zext
    assign w_br_tgt = {{(PC_WIDTH-DATA_WIDTH){1'b0}}, w_rdata1};
  end

  assign w_tgt = w_is_br ? w_br_tgt : w_b_tgt;

  assign w_lu_haz = r_ex_valid & r_ex_ctrl[2] & (r_ex_rd != 4'd0) &
                    ((w_use1 & (w_src1 == r_ex_rd)) | (w_use2 & (w_src2 == r_ex_rd)));
  assign w_flag_haz = w_is_branch & (w_cc != 3'b111) & r_ex_valid & (r_ex_ctrl[7] | r_ex_ctrl[6]);
  assign w_brs_haz  = w_is_br & (w_rs_id != 4'd0) &
                      ((r_ex_valid & r_ex_ctrl[3] & (w_rs_id == r_ex_rd)) |
                       (mem_valid & mem_regwrite & (w_rs_id == mem_rd)));
  assign w_stall = if_valid & (w_lu_haz | w_flag_haz | w_brs_haz);

  assign w_load   = ex_ready | ~r_ex_valid;
  assign id_ready = ~rst & ~r_halted & ~w_stall & w_load;
  assign w_fire   = if_valid & id_ready;

  assign redirect    = w_fire & w_is_branch & (w_taken != if_pred_taken);
  assign redirect_pc = w_fire ? (w_taken ? w_tgt : if_pc_next) : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) r_rf[i] <= '0;
    end else if (wb_we && (wb_rd != 4'd0)) begin
      r_rf[wb_rd] <= wb_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_halted      <= 1'b0;
      r_branch_cnt  <= '0;
      r_mispred_cnt <= '0;
      r_ex_valid    <= 1'b0;
      r_ex_src1     <= '0;
      r_ex_src2     <= '0;
      r_ex_rd       <= '0;
      r_ex_op1      <= '0;
      r_ex_op2      <= '0;
      r_ex_imm      <= '0;
      r_ex_memdata  <= '0;
      r_ex_aluop    <= '0;
      r_ex_ctrl     <= '0;
      r_ex_pc_next  <= '0;
    end else begin
      if (w_fire && w_is_hlt) r_halted <= 1'b1;
      if (w_fire && w_is_branch && !(&r_branch_cnt))
        r_branch_cnt <= r_branch_cnt + CNT_W'(1);
      if (redirect && !(&r_mispred_cnt))
        r_mispred_cnt <= r_mispred_cnt + CNT_W'(1);
      if (w_load) begin
        r_ex_valid   <= w_fire;
        r_ex_src1    <= w_fire ? w_src1   : '0;
        r_ex_src2    <= w_fire ? w_src2   : '0;
        r_ex_rd      <= w_fire ? w_rd_id  : '0;
        r_ex_op1     <= w_fire ? w_rdata1 : '0;
        r_ex_op2     <= w_fire ? w_op2    : '0;
        r_ex_imm     <= w_fire ? w_imm    : '0;
        r_ex_memdata <= w_fire ? w_rdata2 : '0;
        r_ex_aluop   <= w_fire ? w_aluop  : '0;
        r_ex_ctrl    <= w_fire ? w_ctrl   : '0;
        r_ex_pc_next <= w_fire ? if_pc_next : '0;
      end
    end
  end

  assign ex_valid    = r_ex_valid;
  assign ex_src1_id  = r_ex_src1;
  assign ex_src2_id  = r_ex_src2;
  assign ex_rd       = r_ex_rd;
  assign ex_op1      = r_ex_op1;
  assign ex_op2      = r_ex_op2;
  assign ex_imm      = r_ex_imm;
  assign ex_memdata  = r_ex_memdata;
  assign ex_aluop    = r_ex_aluop;
  assign ex_ctrl     = r_ex_ctrl;
  assign ex_pc_next  = r_ex_pc_next;
  assign branch_cnt  = r_branch_cnt;
  assign mispred_cnt = r_mispred_cnt;

endmodule
`default_nettype wire

// File: tb/tb_decode_stage_pl.sv
`default_nettype none
// ============================================================================
// Module   : tb_decode_stage_pl
// Brief    : Scoreboard bench for decode_stage_pl (bypass and no-bypass builds).
// Revision : 1.0  initial release
// ============================================================================
module tb_decode_stage_pl;

  typedef struct packed {
    logic [3:0]  s1, s2, rd;
    logic [15:0] op1, op2, imm, md;
    logic [3:0]  alu;
    logic [8:0]  ctrl;
    logic [15:0] pcn;
  } exp_t;

  logic        clk, rst, if_valid, if_pred_taken, wb_we, mem_valid, mem_regwrite, ex_ready;
  logic [15:0] if_inst, if_pc_next, wb_data;
  logic [2:0]  flags;
  logic [3:0]  wb_rd, mem_rd;

  logic        id_ready, ex_valid, redirect;
  logic [3:0]  ex_src1_id, ex_src2_id, ex_rd, ex_aluop;
  logic [15:0] ex_op1, ex_op2, ex_imm, ex_memdata, ex_pc_next, redirect_pc;
  logic [8:0]  ex_ctrl;
  logic [15:0] branch_cnt, mispred_cnt;

  logic        nb_id_ready, nb_ex_valid, nb_redirect;
  logic [3:0]  nb_src1, nb_src2, nb_rd, nb_aluop;
  logic [15:0] nb_op1, nb_op2, nb_imm, nb_memdata, nb_pc_next, nb_redirect_pc;
  logic [8:0]  nb_ctrl;
  logic [15:0] nb_branch_cnt, nb_mispred_cnt;

  int   checks = 0;
  int   errors = 0;
  exp_t sbq[$];
  logic tb_load;

  decode_stage_pl #(.DATA_WIDTH(16), .PC_WIDTH(16), .BYPASS_EN(1), .CNT_W(16)) u_dut (
    .clk(clk), .rst(rst), .if_valid(if_valid), .if_inst(if_inst), .if_pc_next(if_pc_next),
    .if_pred_taken(if_pred_taken), .id_ready(id_ready), .flags(flags), .wb_we(wb_we),
    .wb_rd(wb_rd), .wb_data(wb_data), .mem_valid(mem_valid), .mem_regwrite(mem_regwrite),
    .mem_rd(mem_rd), .ex_ready(ex_ready), .ex_valid(ex_valid), .ex_src1_id(ex_src1_id),
    .ex_src2_id(ex_src2_id), .ex_rd(ex_rd), .ex_op1(ex_op1), .ex_op2(ex_op2), .ex_imm(ex_imm),
    .ex_memdata(ex_memdata), .ex_aluop(ex_aluop), .ex_ctrl(ex_ctrl), .ex_pc_next(ex_pc_next),
    .redirect(redirect), .redirect_pc(redirect_pc), .branch_cnt(branch_cnt),
    .mispred_cnt(mispred_cnt)
  );

  decode_stage_pl #(.DATA_WIDTH(16), .PC_WIDTH(16), .BYPASS_EN(0), .CNT_W(16)) u_nb (
    .clk(clk), .rst(rst), .if_valid(if_valid), .if_inst(if_inst), .if_pc_next(if_pc_next),
    .if_pred_taken(if_pred_taken), .id_ready(nb_id_ready), .flags(flags), .wb_we(wb_we),
    .wb_rd(wb_rd), .wb_data(wb_data), .mem_valid(mem_valid), .mem_regwrite(mem_regwrite),
    .mem_rd(mem_rd), .ex_ready(ex_ready), .ex_valid(nb_ex_valid), .ex_src1_id(nb_src1),
    .ex_src2_id(nb_src2), .ex_rd(nb_rd), .ex_op1(nb_op1), .ex_op2(nb_op2), .ex_imm(nb_imm),
    .ex_memdata(nb_memdata), .ex_aluop(nb_aluop), .ex_ctrl(nb_ctrl), .ex_pc_next(nb_pc_next),
    .redirect(nb_redirect), .redirect_pc(nb_redirect_pc), .branch_cnt(nb_branch_cnt),
    .mispred_cnt(nb_mispred_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic exp_t mk(input logic [3:0] s1, s2, rd, input logic [15:0] op1, op2, imm, md,
                              input logic [3:0] alu, input logic [8:0] ctrl, input logic [15:0] pcn);
    mk = '{s1: s1, s2: s2, rd: rd, op1: op1, op2: op2, imm: imm, md: md,
           alu: alu, ctrl: ctrl, pcn: pcn};
  endfunction

  // A new ID/EX entry appears only after an edge on which the register loaded
  always @(posedge clk) tb_load <= ex_ready | ~ex_valid;

  always @(negedge clk) begin
    exp_t e, o;
    if (tb_load === 1'b1 && ex_valid === 1'b1) begin
      o = {ex_src1_id, ex_src2_id, ex_rd, ex_op1, ex_op2, ex_imm, ex_memdata,
           ex_aluop, ex_ctrl, ex_pc_next};
      checks++;
      if (sbq.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected: got %h expected no issued instruction", o);
      end else begin
        e = sbq.pop_front();
        if (o !== e) begin
          errors++;
          $display("FAIL sb_idex: got %h expected %h", o, e);
        end
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic wb_write(input logic [3:0] r, input logic [15:0] d);
    wb_we = 1'b1; wb_rd = r; wb_data = d;
    tick();
    wb_we = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; if_valid = 1'b0; if_inst = 16'h0; if_pc_next = 16'h0; if_pred_taken = 1'b0;
    flags = 3'b000; wb_we = 1'b0; wb_rd = 4'h0; wb_data = 16'h0; mem_valid = 1'b0;
    mem_regwrite = 1'b0; mem_rd = 4'h0; ex_ready = 1'b1;
    tick(); tick();
    checks++; if (ex_valid !== 1'b0 || ex_ctrl !== 9'h0) begin errors++;
      $display("FAIL reset_idex: valid=%b ctrl=%h expected 0/000", ex_valid, ex_ctrl); end
    checks++; if (branch_cnt !== 16'h0 || mispred_cnt !== 16'h0) begin errors++;
      $display("FAIL reset_cnt: br=%h mis=%h expected 0/0", branch_cnt, mispred_cnt); end
    checks++; if (id_ready !== 1'b0 || redirect !== 1'b0) begin errors++;
      $display("FAIL reset_ready: id_ready=%b redirect=%b expected 0/0", id_ready, redirect); end
    rst = 1'b0;
    tick();
    checks++; if (id_ready !== 1'b1) begin errors++;
      $display("FAIL post_reset_ready: id_ready=%b expected 1", id_ready); end
  endtask

  task automatic test_regfile;
    wb_write(4'd3, 16'h1111);
    wb_write(4'd4, 16'h0044);
    wb_write(4'd6, 16'h0066);
    wb_write(4'd0, 16'hDEAD);
    if_valid = 1'b1; if_inst = 16'h0734; if_pc_next = 16'h0100;
    sbq.push_back(mk(3, 4, 7, 16'h1111, 16'h0044, 16'h0004, 16'h0044, 4'h0, 9'h0C8, 16'h0100));
    tick();
    if_inst = 16'h0100; if_pc_next = 16'h0102;  // ADD R1,R0,R0: R0 reads zero
    sbq.push_back(mk(0, 0, 1, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 4'h0, 9'h0C8, 16'h0102));
    tick();
    if_valid = 1'b0;
    tick();
  endtask

  task automatic test_bypass;
    if_valid = 1'b1; if_inst = 16'h0134; if_pc_next = 16'h0104;
    wb_we = 1'b1; wb_rd = 4'd3; wb_data = 16'h1234;
    sbq.push_back(mk(3, 4, 1, 16'h1234, 16'h0044, 16'h0004, 16'h0044, 4'h0, 9'h0C8, 16'h0104));
    tick();
    wb_we = 1'b0; if_valid = 1'b0;
    checks++; if (nb_op1 !== 16'h1111) begin errors++;
      $display("FAIL nobypass_op1: got %h expected 1111", nb_op1); end
    tick();
  endtask

  task automatic test_load_use;
    if_valid = 1'b1; if_inst = 16'h8232; if_pc_next = 16'h0106;
    #1;
    checks++; if (id_ready !== 1'b1) begin errors++;
      $display("FAIL lw_ready: id_ready=%b expected 1", id_ready); end
    sbq.push_back(mk(3, 2, 2, 16'h1234, 16'h0002, 16'h0002, 16'h0000, 4'h0, 9'h12C, 16'h0106));
    tick();
    if_inst = 16'h0526; if_pc_next = 16'h0108;
    #1;
    checks++; if (id_ready !== 1'b0) begin errors++;
      $display("FAIL load_use_stall: id_ready=%b expected 0", id_ready); end
    tick();
    checks++; if (ex_valid !== 1'b0 || ex_ctrl !== 9'h0) begin errors++;
      $display("FAIL load_use_bubble: valid=%b ctrl=%h expected 0/000", ex_valid, ex_ctrl); end
    checks++; if (id_ready !== 1'b1) begin errors++;
      $display("FAIL load_use_release: id_ready=%b expected 1", id_ready); end
    sbq.push_back(mk(2, 6, 5, 16'h0000, 16'h0066, 16'h0006, 16'h0066, 4'h0, 9'h0C8, 16'h0108));
    tick();
    if_valid = 1'b0;
    tick();
  endtask

  task automatic test_branch;
    if_valid = 1'b1; if_inst = 16'hC3FE; if_pc_next = 16'h0010; if_pred_taken = 1'b0;
    flags = 3'b100;
    #1;
    checks++; if (redirect !== 1'b1 || redirect_pc !== 16'h000C) begin errors++;
      $display("FAIL b_taken_redirect: redir=%b pc=%h expected 1/000c", redirect, redirect_pc); end
    sbq.push_back(mk(4'hF, 4'hE, 3, 16'h0, 16'h0, 16'h000E, 16'h0, 4'hC, 9'h000, 16'h0010));
    tick();
    checks++; if (branch_cnt !== 16'd1 || mispred_cnt !== 16'd1) begin errors++;
      $display("FAIL b_taken_cnt: br=%0d mis=%0d expected 1/1", branch_cnt, mispred_cnt); end
    flags = 3'b000; if_pc_next = 16'h0012;
    #1;
    checks++; if (redirect !== 1'b0 || redirect_pc !== 16'h0012) begin errors++;
      $display("FAIL b_nt_redirect: redir=%b pc=%h expected 0/0012", redirect, redirect_pc); end
    sbq.push_back(mk(4'hF, 4'hE, 3, 16'h0, 16'h0, 16'h000E, 16'h0, 4'hC, 9'h000, 16'h0012));
    tick();
    if_inst = 16'hDE40; if_pc_next = 16'h0014;
    mem_valid = 1'b1; mem_regwrite = 1'b1; mem_rd = 4'd4;
    #1;
    checks++; if (id_ready !== 1'b0) begin errors++;
      $display("FAIL br_src_stall: id_ready=%b expected 0", id_ready); end
    tick();
    mem_valid = 1'b0;
    #1;
    checks++; if (redirect !== 1'b1 || redirect_pc !== 16'h0044) begin errors++;
      $display("FAIL br_redirect: redir=%b pc=%h expected 1/0044", redirect, redirect_pc); end
    sbq.push_back(mk(4, 0, 4'hE, 16'h0044, 16'h0, 16'h0, 16'h0, 4'hD, 9'h000, 16'h0014));
    tick();
    checks++; if (branch_cnt !== 16'd3 || mispred_cnt !== 16'd2) begin errors++;
      $display("FAIL br_cnt: br=%0d mis=%0d expected 3/2", branch_cnt, mispred_cnt); end
    if_valid = 1'b0;
    tick();
  endtask

  task automatic test_flag_hazard;
    flags = 3'b000; if_pred_taken = 1'b1;
    if_valid = 1'b1; if_inst = 16'h1134; if_pc_next = 16'h0200;
    sbq.push_back(mk(3, 4, 1, 16'h1234, 16'h0044, 16'h0004, 16'h0044, 4'h1, 9'h0C8, 16'h0200));
    tick();
    if_inst = 16'hC000; if_pc_next = 16'h0202;
    #1;
    checks++; if (id_ready !== 1'b0) begin errors++;
      $display("FAIL flag_stall: id_ready=%b expected 0", id_ready); end
    tick();
    checks++; if (ex_valid !== 1'b0 || redirect !== 1'b0 || id_ready !== 1'b1) begin errors++;
      $display("FAIL flag_release: valid=%b redir=%b ready=%b expected 0/0/1",
               ex_valid, redirect, id_ready); end
    sbq.push_back(mk(0, 0, 0, 16'h0, 16'h0, 16'h0, 16'h0, 4'hC, 9'h000, 16'h0202));
    tick();
    if_inst = 16'h1134; if_pc_next = 16'h0204;
    sbq.push_back(mk(3, 4, 1, 16'h1234, 16'h0044, 16'h0004, 16'h0044, 4'h1, 9'h0C8, 16'h0204));
    tick();
    if_inst = 16'hCE00; if_pc_next = 16'h0206;
    #1;
    checks++; if (id_ready !== 1'b1) begin errors++;
      $display("FAIL uncond_no_stall: id_ready=%b expected 1", id_ready); end
    sbq.push_back(mk(0, 0, 4'hE, 16'h0, 16'h0, 16'h0, 16'h0, 4'hC, 9'h000, 16'h0206));
    tick();
    checks++; if (branch_cnt !== 16'd5 || mispred_cnt !== 16'd2) begin errors++;
      $display("FAIL flag_cnt: br=%0d mis=%0d expected 5/2", branch_cnt, mispred_cnt); end
    if_valid = 1'b0; if_pred_taken = 1'b0;
    tick();
  endtask

  task automatic test_backpressure;
    exp_t a, o;
    a = mk(3, 4, 7, 16'h1234, 16'h0044, 16'h0004, 16'h0044, 4'h0, 9'h0C8, 16'h0300);
    if_valid = 1'b1; if_inst = 16'h0734; if_pc_next = 16'h0300;
    sbq.push_back(a);
    tick();
    ex_ready = 1'b0; if_inst = 16'h2834; if_pc_next = 16'h0302;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (id_ready !== 1'b0) begin errors++;
        $display("FAIL hold_ready[%0d]: id_ready=%b expected 0", i, id_ready); end
      tick();
      o = {ex_src1_id, ex_src2_id, ex_rd, ex_op1, ex_op2, ex_imm, ex_memdata,
           ex_aluop, ex_ctrl, ex_pc_next};
      checks++; if (o !== a || ex_valid !== 1'b1) begin errors++;
        $display("FAIL hold_idex[%0d]: got %h v=%b expected %h v=1", i, o, ex_valid, a); end
    end
    ex_ready = 1'b1;
    #1;
    checks++; if (id_ready !== 1'b1) begin errors++;
      $display("FAIL hold_release: id_ready=%b expected 1", id_ready); end
    sbq.push_back(mk(3, 4, 8, 16'h1234, 16'h0044, 16'h0004, 16'h0044, 4'h2, 9'h088, 16'h0302));
    tick();
    if_valid = 1'b0;
    tick();
  endtask

  task automatic test_halt;
    if_valid = 1'b1; if_inst = 16'hF000; if_pc_next = 16'h0400;
    sbq.push_back(mk(0, 0, 0, 16'h0, 16'h0, 16'h0, 16'h0, 4'hF, 9'h002, 16'h0400));
    tick();
    if_inst = 16'h0734; if_pc_next = 16'h0402;
    for (int i = 0; i < 10; i++) begin
      #1;
      checks++; if (id_ready !== 1'b0) begin errors++;
        $display("FAIL halted_ready[%0d]: id_ready=%b expected 0", i, id_ready); end
      tick();
    end
    checks++; if (ex_valid !== 1'b0) begin errors++;
      $display("FAIL halted_bubble: ex_valid=%b expected 0", ex_valid); end
    rst = 1'b1;
    #1;
    checks++; if (id_ready !== 1'b0) begin errors++;
      $display("FAIL rst_ready: id_ready=%b expected 0", id_ready); end
    tick();
    rst = 1'b0;
    checks++; if (branch_cnt !== 16'h0 || mispred_cnt !== 16'h0 || ex_ctrl !== 9'h0 ||
                  ex_op1 !== 16'h0 || ex_pc_next !== 16'h0) begin errors++;
      $display("FAIL rst_clear: br=%h mis=%h ctrl=%h op1=%h pcn=%h expected all 0",
               branch_cnt, mispred_cnt, ex_ctrl, ex_op1, ex_pc_next); end
    if_inst = 16'h0134; if_pc_next = 16'h0500;
    #1;
    checks++; if (id_ready !== 1'b1) begin errors++;
      $display("FAIL rst_unhalt: id_ready=%b expected 1", id_ready); end
    sbq.push_back(mk(3, 4, 1, 16'h0, 16'h0, 16'h0004, 16'h0, 4'h0, 9'h0C8, 16'h0500));
    tick();
    if_valid = 1'b0;
    tick(); tick();
  endtask

  initial begin
    test_reset();
    test_regfile();
    test_bypass();
    test_load_use();
    test_branch();
    test_flag_hazard();
    test_backpressure();
    test_halt();
    checks++; if (sbq.size() != 0) begin errors++;
      $display("FAIL sb_leftover: %0d entries pending expected 0", sbq.size()); end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
